// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch requests, response FIFO with
// branch flush and stale-response dropping, sticky protocol error on unsolicited responses.
module fetch_prefetch_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   freeze_i,
    input  logic                   branch_taken_i,
    input  logic [ADDR_W-1:0]      branch_adr_i,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [ADDR_W-1:0]      req_addr_o,
    input  logic                   resp_valid_i,
    input  logic [DATA_W-1:0]      resp_data_i,
    output logic                   out_valid_o,
    output logic [DATA_W-1:0]      out_instr_o,
    output logic [ADDR_W-1:0]      out_pc_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   protocol_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CW:0]       DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic              perr_q, perr_d;

    logic [DATA_W-1:0] mem_instr_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q    [DEPTH];

    logic [CW:0] credit_sum;
    logic        accept;
    logic        resp_ok;
    logic        resp_err;
    logic        push;
    logic        stale;
    logic        pop;

    // Requests are credited against queue space plus everything still in flight, so a
    // kept response can never find the queue full.
    assign credit_sum  = {1'b0, occ_q} + {1'b0, outst_q};
    assign req_valid_o = rst_ni && (credit_sum < DEPTH_W) && !branch_taken_i;
    assign req_addr_o  = fetch_pc_q;
    assign accept      = req_valid_o && req_ready_i;

    assign resp_ok  = resp_valid_i && (outst_q != '0);
    assign resp_err = resp_valid_i && (outst_q == '0);
    assign push     = resp_ok && (drop_q == '0) && !branch_taken_i;
    assign stale    = resp_ok && (drop_q != '0) && !branch_taken_i;

    assign out_valid_o    = (occ_q != '0);
    assign pop            = out_valid_o && !freeze_i && !branch_taken_i;
    assign out_instr_o    = mem_instr_q[head_q];
    assign out_pc_o       = mem_pc_q[head_q] + STEP;
    assign occupancy_o    = occ_q;
    assign protocol_err_o = perr_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        perr_d     = perr_q | resp_err;
        outst_d    = outst_q + CW'(accept) - CW'(resp_ok);
        occ_d      = occ_q + CW'(push) - CW'(pop);

        if (accept) fetch_pc_d = fetch_pc_q + STEP;
        if (push) begin
            resp_pc_d = resp_pc_q + STEP;
            tail_d    = tail_q + PW'(1);
        end
        if (stale) drop_d = drop_q - CW'(1);
        if (pop)   head_d = head_q + PW'(1);

        // A redirect flushes everything; a response landing in the same cycle is already
        // answered, so only the remaining in-flight requests need dropping later.
        if (branch_taken_i) begin
            fetch_pc_d = branch_adr_i;
            resp_pc_d  = branch_adr_i;
            drop_d     = outst_q - CW'(resp_ok);
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            perr_q     <= perr_d;
        end
    end

    // Storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr_q[tail_q] <= resp_data_i;
            mem_pc_q[tail_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: reset, streaming, full, flush, branch collisions,
// protocol error and mid-stream reset, against hand-computed values.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_adr = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;
    logic        protocol_err;

    int total = 0;
    int bad = 0;

    logic        auto_mem = 1'b0;
    logic        mem_stall = 1'b0;
    logic        acc_n = 1'b0;
    logic [31:0] adr_n = '0;
    logic [31:0] pend [$];

    fetch_prefetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze), .branch_taken_i(branch_taken),
        .branch_adr_i(branch_adr), .req_valid_o(req_valid), .req_ready_i(req_ready),
        .req_addr_o(req_addr), .resp_valid_i(resp_valid), .resp_data_i(resp_data),
        .out_valid_o(out_valid), .out_instr_o(out_instr), .out_pc_o(out_pc),
        .occupancy_o(occupancy), .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    // Memory model: returns data = address, one cycle after acceptance unless stalled.
    always @(negedge clk) begin
        acc_n = req_valid && req_ready;
        adr_n = req_addr;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend.delete();
            resp_valid = 1'b0;
        end else if (auto_mem) begin
            if (acc_n) pend.push_back(adr_n);
            if (!mem_stall && pend.size() > 0) begin
                resp_valid = 1'b1;
                resp_data  = pend.pop_front();
            end else begin
                resp_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; auto_mem = 1'b0; mem_stall = 1'b0; req_ready = 1'b0;
        freeze = 1'b0; branch_taken = 1'b0; resp_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got %0h want 0", req_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rst_perr got %0h want 0", protocol_err); end
        rst_n = 1'b1;
        #1;
        total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rel_req_valid got %0h want 1", req_valid); end
        total++; if (req_addr !== 32'h0) begin bad++; $display("FAIL rel_req_addr got %0h want 0", req_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        auto_mem = 1'b1; req_ready = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got %0h want 1", k, out_valid); end
            total++; if (out_pc !== 32'(4*(k+1))) begin bad++; $display("FAIL stream_pc[%0d] got %0h want %0h", k, out_pc, 4*(k+1)); end
            total++; if (out_instr !== 32'(4*k)) begin bad++; $display("FAIL stream_instr[%0d] got %0h want %0h", k, out_instr, 4*k); end
            total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL stream_occ[%0d] got %0d want 1", k, occupancy); end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        auto_mem = 1'b1; req_ready = 1'b1; freeze = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #1;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got %0d want 4", occupancy); end
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got %0h want 0", req_valid); end
        total++; if (out_pc !== 32'd4) begin bad++; $display("FAIL full_head_pc got %0h want 4", out_pc); end
        tick();
        tick();
        total++; if (out_pc !== 32'd4 || out_instr !== 32'd0) begin bad++; $display("FAIL full_hold got %0h/%0h want 4/0", out_pc, out_instr); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ_hold got %0d want 4", occupancy); end
        freeze = 1'b0;
        #1;
        total++; if (out_pc !== 32'd4) begin bad++; $display("FAIL full_pop0 got %0h want 4", out_pc); end
        tick();
        total++; if (out_pc !== 32'd8) begin bad++; $display("FAIL full_pop1 got %0h want 8", out_pc); end
        total++; if (req_valid !== 1'b1 || req_addr !== 32'd16) begin bad++; $display("FAIL full_resume got %0h/%0h want 1/10", req_valid, req_addr); end
        tick();
        total++; if (out_pc !== 32'd12) begin bad++; $display("FAIL full_pop2 got %0h want c", out_pc); end
        tick();
        total++; if (out_pc !== 32'd16) begin bad++; $display("FAIL full_pop3 got %0h want 10", out_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        auto_mem = 1'b1; mem_stall = 1'b1; req_ready = 1'b1;
        tick();
        tick();
        req_ready = 1'b0; branch_taken = 1'b1; branch_adr = 32'h100;
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL flush_req_masked got %0h want 0", req_valid); end
        tick();
        branch_taken = 1'b0; req_ready = 1'b1; mem_stall = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got %0d/%0h want 0/0", occupancy, out_valid); end
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin bad++; $display("FAIL flush_target got %0h/%0h want 1/100", req_valid, req_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d] got %0h want 0", i, out_valid); end
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin bad++; $display("FAIL flush_first_pc got %0h/%0h want 1/104", out_valid, out_pc); end
        total++; if (out_instr !== 32'h100) begin bad++; $display("FAIL flush_first_instr got %0h want 100", out_instr); end
    endtask

    task automatic test_simul();
        do_reset();
        auto_mem = 1'b1; req_ready = 1'b1;
        tick();
        tick();
        tick();
        branch_taken = 1'b1; freeze = 1'b1; branch_adr = 32'h200;
        #1;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL simul_setup got %0h want 1", resp_valid); end
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL simul_req_masked got %0h want 0", req_valid); end
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL simul_empty got %0d/%0h want 0/0", occupancy, out_valid); end
        total++; if (req_addr !== 32'h200) begin bad++; $display("FAIL simul_target got %0h want 200", req_addr); end
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin bad++; $display("FAIL simul_kept got %0h/%0h want 1/204", out_valid, out_pc); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL simul_perr got %0h want 0", protocol_err); end
    endtask

    task automatic test_err();
        do_reset();
        resp_valid = 1'b1; resp_data = 32'hdead;
        #1;
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL err_before got %0h want 0", protocol_err); end
        tick();
        resp_valid = 1'b0;
        #1;
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_set got %0h want 1", protocol_err); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL err_ignored got %0d want 0", occupancy); end
        auto_mem = 1'b1; req_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_sticky got %0h want 1", protocol_err); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL err_stream got %0h want 1", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_mem = 1'b1; req_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        total++; if (req_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valids got %0h/%0h want 0/0", req_valid, out_valid); end
        total++; if (occupancy !== 3'd0 || protocol_err !== 1'b0) begin bad++; $display("FAIL mid_rst_state got %0d/%0h want 0/0", occupancy, protocol_err); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin bad++; $display("FAIL mid_restart got %0h/%0h want 1/0", req_valid, req_addr); end
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'd4 || out_instr !== 32'd0) begin bad++; $display("FAIL mid_first got %0h/%0h/%0h want 1/4/0", out_valid, out_pc, out_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_simul();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 The block SHALL have parameter PC_STEP, default 4, byte increment per fetch.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst input 1 (0 = reset, asynchronous assert).
REQ-006 The block SHALL have freeze input 1, hazard stall from decode; blocks dequeue only.
REQ-007 The block SHALL have branch_taken input 1, single-cycle redirect pulse.
REQ-008 The block SHALL have branch_adr input ADDR_W, redirect target.
REQ-009 The block SHALL have req_valid output 1, fetch request to instruction memory.
REQ-010 The block SHALL have req_ready input 1, memory accepts the request.
REQ-011 The block SHALL have req_addr output ADDR_W, fetch address.
REQ-012 The block SHALL have resp_valid input 1, in-order response, at most one per cycle.
REQ-013 The block SHALL have resp_data input DATA_W, returned instruction.
REQ-014 The block SHALL have out_valid output 1, queue head valid.
REQ-015 The block SHALL have out_instr output DATA_W, head instruction.
REQ-016 The block SHALL have out_pc output ADDR_W, head fetch address + PC_STEP.
REQ-017 The block SHALL have occupancy output clog2(DEPTH)+1, entries held.
REQ-018 The block SHALL have protocol_err output 1, sticky unexpected-response flag.

Function
REQ-019 The block SHALL hold three counters: fetch_pc (next request address), resp_pc (address of next kept response) and outstanding (issued, unanswered requests); outstanding range is 0..DEPTH.
REQ-020 The block SHALL drive req_valid = (occupancy + outstanding < DEPTH) and not branch_taken, and req_addr = fetch_pc.
REQ-021 The block SHALL treat a request as accepted in a cycle where req_valid and req_ready are both 1; it then adds PC_STEP to fetch_pc (modulo 2^ADDR_W) and increments outstanding.
REQ-022 The block SHALL keep a response when resp_valid=1 and drop=0: it writes {resp_pc, resp_data} at the tail, adds PC_STEP to resp_pc and decrements outstanding.
REQ-023 The block SHALL treat a response arriving while drop>0 as stale: it discards the response, decrements drop and decrements outstanding.
REQ-024 The block SHALL set protocol_err and ignore the response when resp_valid=1 while outstanding=0; protocol_err clears only on reset.
REQ-025 The block SHALL drive out_valid = (occupancy != 0) combinationally, with out_instr/out_pc from the head entry (out_pc = stored address + PC_STEP).
REQ-026 The block SHALL pop the head when out_valid=1, freeze=0 and branch_taken=0; out_instr/out_pc hold stable while freeze=1.
REQ-027 The block SHALL allow a simultaneous push and pop in one cycle, leaving occupancy unchanged; a pop and a push on a full queue are legal together.
REQ-028 The block SHALL wrap head/tail pointers modulo DEPTH.
REQ-029 The block SHALL never exceed DEPTH entries, because a response is only possible for a credited request (REQ-020).
REQ-030 On branch_taken=1 the block SHALL, at the next edge: empty the queue; load fetch_pc and resp_pc with branch_adr; set drop = outstanding - (resp_valid ? 1 : 0); treat any same-cycle response as stale; issue and pop nothing that cycle.
REQ-031 The block SHALL give branch_taken priority over freeze and over any pop or push in the same cycle.
REQ-032 The block SHALL allow a new branch_taken while drop>0; drop is then recomputed per REQ-030 from the current outstanding.
REQ-033 The block SHALL add one cycle of latency from a kept response to out_valid; back-to-back fetch, response and dequeue SHALL sustain one instruction per cycle.

Reset
REQ-034 While rst=0 the block SHALL force fetch_pc=0, resp_pc=0, outstanding=0, drop=0, occupancy=0, pointers=0, protocol_err=0, req_valid=0 and out_valid=0, asynchronously.
REQ-035 The block SHALL set req_valid=1 with req_addr=0 in the first cycle after rst deasserts; assertion of rst mid-operation abandons all queued and in-flight state.

Verification
REQ-036 Streaming: req_ready=1, responses 1 cycle late with data = address, freeze=0 -> out_pc 4, 8, 12, ... one per cycle, out_instr = out_pc-4.
REQ-037 Full: DEPTH=4, freeze=1 -> occupancy reaches 4, req_valid=0, head stable; release freeze -> four pops, then fetch resumes at 16.
REQ-038 Flush: 2 outstanding, branch_taken with branch_adr=0x100 -> next two responses discarded, first out_pc=0x104, queue empty in the cycle after the branch.
REQ-039 Simultaneous: branch_taken with freeze=1 and resp_valid=1 in the same cycle -> branch wins, that response is dropped, drop = outstanding-1.
REQ-040 Errors and reset: resp_valid with outstanding=0 -> protocol_err=1 and sticky; rst pulse mid-stream -> all outputs at reset values, restart at address 0.
